// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encoding, issuer FSM state encoding and the
// legal-opcode check. Used by both the command issuer and the ALU itself.
package alu_pkg;

  localparam int unsigned DATA_W = 32;

  typedef enum logic [2:0] {
    OP_AND  = 3'b000,
    OP_OR   = 3'b001,
    OP_ADD  = 3'b010,
    OP_SUB  = 3'b011,
    OP_COMP = 3'b100
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_RESP    = 2'd3
  } issuer_state_e;

  // Opcodes 101..111 are reserved and never reach the ALU.
  function automatic logic is_legal_op(input logic [2:0] op);
    return (op <= OP_COMP);
  endfunction

endpackage

// File: rtl/alu_cmd_issuer_if.sv
// Bundle of command, ALU and response signals around the issuer.
// slave  : the issuer's view (takes commands, drives ALU inputs and responses).
// master : the surrounding system's view (offers commands, consumes responses,
//          supplies the ALU result).
interface alu_cmd_issuer_if;
  import alu_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [2:0]        cmd_op;
  logic [DATA_W-1:0] cmd_a;
  logic [DATA_W-1:0] cmd_b;

  logic [2:0]        alu_opcode;
  logic [DATA_W-1:0] alu_operand1;
  logic [DATA_W-1:0] alu_operand2;
  logic [DATA_W-1:0] alu_result;
  logic              alu_flag_c;
  logic              alu_flag_z;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_result;
  logic              rsp_flag_c;
  logic              rsp_flag_z;
  logic              rsp_err;

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b,
    input  alu_result, alu_flag_c, alu_flag_z,
    input  rsp_ready,
    output cmd_ready,
    output alu_opcode, alu_operand1, alu_operand2,
    output rsp_valid, rsp_result, rsp_flag_c, rsp_flag_z, rsp_err
  );

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b,
    output alu_result, alu_flag_c, alu_flag_z,
    output rsp_ready,
    input  cmd_ready,
    input  alu_opcode, alu_operand1, alu_operand2,
    input  rsp_valid, rsp_result, rsp_flag_c, rsp_flag_z, rsp_err
  );

endinterface

// File: rtl/alu.sv
// Team 32-bit combinational ALU. Carry on SUB is the borrow (a < b unsigned);
// COMP returns 1 when a < b (unsigned), else 0. Zero flag follows the result.
module alu
  import alu_pkg::*;
(
  input  logic [2:0]        opcode,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result,
  output logic              flag_c,
  output logic              flag_z
);

  // Combinational operation select; reserved opcodes yield zero.
  always_comb begin
    // NOTE: every output gets a default first so no path infers a latch.
    result = '0;
    flag_c = 1'b0;
    unique case (opcode)
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_ADD:  {flag_c, result} = {1'b0, a} + {1'b0, b};
      OP_SUB:  {flag_c, result} = {1'b0, a} - {1'b0, b};
      OP_COMP: result = {{(DATA_W-1){1'b0}}, (a < b)};
      default: result = '0;
    endcase
    flag_z = (result == '0);
  end

endmodule

// File: rtl/alu_cmd_issuer.sv
// ALU command issuer: accepts one command at a time, drives registered
// operands to an external combinational ALU, waits one settle cycle, captures
// the result and holds it as a response until the consumer takes it.
// Reserved opcodes bypass the ALU and answer immediately with rsp_err set.
// Optional build macro ALU_ISSUER_STATS_EN adds completed-command counters.
module alu_cmd_issuer
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  alu_cmd_issuer_if.slave   bus,
  output logic              busy
`ifdef ALU_ISSUER_STATS_EN
  ,
  output logic [15:0]       stat_issued,
  output logic [15:0]       stat_err
`endif
);

  issuer_state_e state_q, state_d;
  logic          accept;
  logic          legal;
  logic          rsp_done;

  assign accept   = bus.cmd_valid && bus.cmd_ready;
  assign legal    = is_legal_op(bus.cmd_op);
  assign rsp_done = (state_q == ST_RESP) && bus.rsp_ready;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (accept) state_d = legal ? ST_ISSUE : ST_RESP;
      ST_ISSUE:   state_d = ST_CAPTURE;
      ST_CAPTURE: state_d = ST_RESP;
      ST_RESP:    if (bus.rsp_ready) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // State-decoded handshake and status outputs.
  always_comb begin
    bus.cmd_ready = (state_q == ST_IDLE);
    bus.rsp_valid = (state_q == ST_RESP);
    busy          = (state_q != ST_IDLE);
  end

  // ALU operand registers: loaded only by a legal accept, otherwise held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.alu_opcode   <= '0;
      bus.alu_operand1 <= '0;
      bus.alu_operand2 <= '0;
    end else if (accept && legal) begin
      bus.alu_opcode   <= bus.cmd_op;
      bus.alu_operand1 <= bus.cmd_a;
      bus.alu_operand2 <= bus.cmd_b;
    end
  end

  // Response registers: error response on an illegal accept, ALU capture in
  // CAPTURE; untouched in RESP so the response is stable under back-pressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.rsp_result <= '0;
      bus.rsp_flag_c <= 1'b0;
      bus.rsp_flag_z <= 1'b0;
      bus.rsp_err    <= 1'b0;
    end else if (accept && !legal) begin
      bus.rsp_result <= '0;
      bus.rsp_flag_c <= 1'b0;
      bus.rsp_flag_z <= 1'b0;
      bus.rsp_err    <= 1'b1;
    end else if (state_q == ST_CAPTURE) begin
      bus.rsp_result <= bus.alu_result;
      bus.rsp_flag_c <= bus.alu_flag_c;
      bus.rsp_flag_z <= bus.alu_flag_z;
      bus.rsp_err    <= 1'b0;
    end
  end

`ifdef ALU_ISSUER_STATS_EN
  // Completed-command counters, bumped on the response handshake; wrap freely.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_issued <= '0;
      stat_err    <= '0;
    end else if (rsp_done) begin
      if (bus.rsp_err) stat_err    <= stat_err + 16'd1;
      else             stat_issued <= stat_issued + 16'd1;
    end
  end
`else
  logic unused_rsp_done;
  assign unused_rsp_done = rsp_done;
`endif

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Bench for alu_cmd_issuer paired with the team ALU: a table of directed
// commands with hand-computed responses, plus sequences for back-pressure,
// reset mid-operation and (with ALU_ISSUER_STATS_EN) the counters.
module tb_alu_cmd_issuer;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic busy;
`ifdef ALU_ISSUER_STATS_EN
  logic [15:0] stat_issued;
  logic [15:0] stat_err;
`endif

  alu_cmd_issuer_if bus();

  alu_cmd_issuer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy)
`ifdef ALU_ISSUER_STATS_EN
    ,
    .stat_issued (stat_issued),
    .stat_err    (stat_err)
`endif
  );

  alu u_alu (
    .opcode (bus.alu_opcode),
    .a      (bus.alu_operand1),
    .b      (bus.alu_operand2),
    .result (bus.alu_result),
    .flag_c (bus.alu_flag_c),
    .flag_z (bus.alu_flag_z)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        c;
    logic        z;
    logic        err;
    int          lat;
    logic [2:0]  exp_op;   // alu_opcode expected after the command
  } vec_t;

  vec_t vecs[10];

  // Offer one command from IDLE (called #1 after an edge), return the number
  // of cycles from the accept edge until rsp_valid is seen (0 on timeout).
  task automatic do_cmd(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int lat);
    int n;
    check("cmd_ready_idle", 32'(bus.cmd_ready), 32'd1);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_a     = a;
    bus.cmd_b     = b;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    check("busy_after_accept", 32'(busy), 32'd1);
    check("cmd_ready_after_accept", 32'(bus.cmd_ready), 32'd0);
    n = 0;
    while (!bus.rsp_valid && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.rsp_valid) begin
      check("rsp_valid_timeout", 32'(bus.rsp_valid), 32'd1);
      lat = 0;
    end else begin
      lat = n + 1;
    end
  endtask

  // Take the response with rsp_ready=1 and confirm return to IDLE.
  task automatic handshake();
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("rsp_valid_after_hs", 32'(bus.rsp_valid), 32'd0);
    check("busy_after_hs", 32'(busy), 32'd0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_cmd_ready"},  32'(bus.cmd_ready),  32'd1);
    check({tag, "_rsp_valid"},  32'(bus.rsp_valid),  32'd0);
    check({tag, "_busy"},       32'(busy),           32'd0);
    check({tag, "_rsp_result"}, bus.rsp_result,      32'd0);
    check({tag, "_rsp_flags"},  {29'd0, bus.rsp_flag_c, bus.rsp_flag_z, bus.rsp_err}, 32'd0);
    check({tag, "_alu_opcode"}, 32'(bus.alu_opcode), 32'd0);
    check({tag, "_alu_op1"},    bus.alu_operand1,    32'd0);
    check({tag, "_alu_op2"},    bus.alu_operand2,    32'd0);
`ifdef ALU_ISSUER_STATS_EN
    check({tag, "_stat_issued"}, 32'(stat_issued), 32'd0);
    check({tag, "_stat_err"},    32'(stat_err),    32'd0);
`endif
  endtask

  initial begin
    int lat;

    vecs[0] = '{3'b010, 32'd5,          32'd7,          32'd12,         1'b0, 1'b0, 1'b0, 3, 3'b010};
    vecs[1] = '{3'b011, 32'd9,          32'd9,          32'd0,          1'b0, 1'b1, 1'b0, 3, 3'b011};
    vecs[2] = '{3'b111, 32'd1,          32'd1,          32'd0,          1'b0, 1'b0, 1'b1, 1, 3'b011};
    vecs[3] = '{3'b000, 32'h0000_00F0,  32'h0000_003C,  32'h0000_0030,  1'b0, 1'b0, 1'b0, 3, 3'b000};
    vecs[4] = '{3'b001, 32'h0000_00F0,  32'h0000_000F,  32'h0000_00FF,  1'b0, 1'b0, 1'b0, 3, 3'b001};
    vecs[5] = '{3'b010, 32'hFFFF_FFFF,  32'd1,          32'd0,          1'b1, 1'b1, 1'b0, 3, 3'b010};
    vecs[6] = '{3'b011, 32'd3,          32'd5,          32'hFFFF_FFFE,  1'b1, 1'b0, 1'b0, 3, 3'b011};
    vecs[7] = '{3'b100, 32'd3,          32'd4,          32'd1,          1'b0, 1'b0, 1'b0, 3, 3'b100};
    vecs[8] = '{3'b100, 32'd4,          32'd3,          32'd0,          1'b0, 1'b1, 1'b0, 3, 3'b100};
    vecs[9] = '{3'b101, 32'h0000_AAAA,  32'h0000_5555,  32'd0,          1'b0, 1'b0, 1'b1, 1, 3'b100};

    rst_n         = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = '0;
    bus.cmd_a     = '0;
    bus.cmd_b     = '0;
    bus.rsp_ready = 1'b1;

    #2;
    check_reset_values("por");
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    // Directed table with the consumer always ready.
    for (int i = 0; i < 10; i++) begin
      do_cmd(vecs[i].op, vecs[i].a, vecs[i].b, lat);
      check($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      check($sformatf("v%0d_result", i), bus.rsp_result, vecs[i].res);
      check($sformatf("v%0d_flag_c", i), 32'(bus.rsp_flag_c), 32'(vecs[i].c));
      check($sformatf("v%0d_flag_z", i), 32'(bus.rsp_flag_z), 32'(vecs[i].z));
      check($sformatf("v%0d_err", i), 32'(bus.rsp_err), 32'(vecs[i].err));
      check($sformatf("v%0d_alu_opcode", i), 32'(bus.alu_opcode), 32'(vecs[i].exp_op));
      handshake();
    end

    // Back-pressure: COMP 3<4 held for 5 cycles while another command waits.
    bus.rsp_ready = 1'b0;
    do_cmd(3'b100, 32'd3, 32'd4, lat);
    check("bp_latency", 32'(lat), 32'd3);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 3'b010;
    bus.cmd_a     = 32'd100;
    bus.cmd_b     = 32'd200;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check($sformatf("bp%0d_rsp_valid", k), 32'(bus.rsp_valid), 32'd1);
      check($sformatf("bp%0d_result", k), bus.rsp_result, 32'd1);
      check($sformatf("bp%0d_err", k), 32'(bus.rsp_err), 32'd0);
      check($sformatf("bp%0d_cmd_ready", k), 32'(bus.cmd_ready), 32'd0);
    end
    bus.cmd_valid = 1'b0;
    check("bp_alu_opcode_held", 32'(bus.alu_opcode), 32'(OP_COMP));
    check("bp_alu_op1_held", bus.alu_operand1, 32'd3);
    handshake();

    // Reset while in CAPTURE abandons the command.
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 3'b010;
    bus.cmd_a     = 32'h1234;
    bus.cmd_b     = 32'h1111;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    @(posedge clk); #1;
    check("cap_busy", 32'(busy), 32'd1);
    check("cap_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    rst_n = 1'b0;
    #1;
    check_reset_values("midrst");
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      check($sformatf("post_rst%0d_rsp_valid", k), 32'(bus.rsp_valid), 32'd0);
      check($sformatf("post_rst%0d_busy", k), 32'(busy), 32'd0);
    end
    do_cmd(3'b000, 32'h0000_00F0, 32'h0000_003C, lat);
    check("post_rst_and_latency", 32'(lat), 32'd3);
    check("post_rst_and_result", bus.rsp_result, 32'h0000_0030);
    check("post_rst_and_err", 32'(bus.rsp_err), 32'd0);
    handshake();

`ifdef ALU_ISSUER_STATS_EN
    // Since the last reset: AND above, then 2 more legal and 2 illegal.
    do_cmd(3'b010, 32'd1, 32'd1, lat);
    handshake();
    do_cmd(3'b110, 32'd1, 32'd1, lat);
    handshake();
    do_cmd(3'b001, 32'd2, 32'd4, lat);
    handshake();
    do_cmd(3'b111, 32'd1, 32'd1, lat);
    handshake();
    check("stat_issued", 32'(stat_issued), 32'd3);
    check("stat_err", 32'(stat_err), 32'd2);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_cmd_issuer.md
ALU_CMD_ISSUER -- requirements
Module: alu_cmd_issuer

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset.
REQ-002 SHALL have ports (name, direction, width, meaning):
- clk  in  1  sole clock, rising edge
- rst_n  in  1  async active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  issuer can accept command
- cmd_op  in  3  opcode: AND 000, OR 001, ADD 010, SUB 011, COMP 100
- cmd_a, cmd_b  in  32  operands
- alu_opcode  out  3  registered opcode to ALU
- alu_operand1, alu_operand2  out  32  registered operands to ALU
- alu_result  in  32  ALU result (combinational)
- alu_flag_c, alu_flag_z  in  1  ALU carry / zero flags
- rsp_valid  out  1  response held
- rsp_ready  in  1  consumer accepts response
- rsp_result  out  32  captured result
- rsp_flag_c, rsp_flag_z  out  1  captured flags
- rsp_err  out  1  illegal opcode (101..111)
- busy  out  1  FSM not in IDLE
REQ-003 SHALL add, with ALU_ISSUER_STATS_EN only: stat_issued out 16 (legal commands completed), stat_err out 16 (illegal commands completed).

Function
REQ-004 SHALL implement FSM states IDLE, ISSUE, CAPTURE, RESP.
REQ-005 SHALL assert cmd_ready only in IDLE; a command is accepted on a rising edge with cmd_valid=1 and cmd_ready=1.
REQ-006 On a legal accept, SHALL load cmd_op/a/b into alu_opcode/operand1/operand2 and go IDLE->ISSUE.
REQ-007 ISSUE SHALL last exactly one cycle (ALU settle), then go to CAPTURE.
REQ-008 CAPTURE SHALL register alu_result, alu_flag_c and alu_flag_z into rsp_* with rsp_err=0, then go to RESP.
REQ-009 On an illegal-opcode accept, SHALL skip ISSUE/CAPTURE, go IDLE->RESP, and set rsp_result=0, flags=0, rsp_err=1; ALU output registers keep their prior values.
REQ-010 SHALL assert rsp_valid only in RESP; rsp_* SHALL stay stable while rsp_valid=1 and rsp_ready=0.
REQ-011 RESP->IDLE SHALL occur on a rising edge with rsp_ready=1; there is no response drop.
REQ-012 Latency from accept edge to rsp_valid high: legal 3 cycles, illegal 1 cycle; with rsp_ready held at 1, legal throughput is one command per 4 cycles.
REQ-013 Commands SHALL never be accepted while a response is pending; there is no overlap or buffering beyond one command.
REQ-014 busy SHALL equal (state != IDLE).
REQ-015 COMP result is exactly 0 or 1 and SHALL be captured as given by the ALU, with no reinterpretation.
REQ-016 Stats counters SHALL increment on the RESP->IDLE edge and wrap at 16'hFFFF->0.

Reset
REQ-017 rst_n low SHALL immediately force: state=IDLE, cmd_ready=1 (combinational from IDLE), rsp_valid=0, rsp_result=0, rsp_flag_c=0, rsp_flag_z=0, rsp_err=0, alu_opcode=0, alu_operand1=0, alu_operand2=0, busy=0, stats=0.
REQ-018 Reset mid-operation SHALL abandon the in-flight command with no response produced.

Configuration
REQ-019 With ALU_ISSUER_STATS_EN defined, SHALL include stat_issued/stat_err ports and counters; without it, neither ports nor logic exist, and all other behaviour is identical.

Structure
REQ-020 Opcode constants (AND/OR/ADD/SUB/COMP), the FSM state encoding, and the legal-opcode check SHALL live in shared package alu_pkg, reusable by the ALU.
REQ-021 Issuer SHALL be a single module with no sub-modules; the ALU is instantiated externally alongside it.

Verification
REQ-022 Bench SHALL pair the issuer with the team's 32-bit ALU and cover:
- ADD a=5, b=7, rsp_ready=1 -> rsp_valid 3 cycles after accept, rsp_result=12, rsp_err=0, flag_z=0.
- SUB a=9, b=9 -> rsp_result=0, rsp_flag_z=1.
- cmd_op=111, a=1, b=1 -> rsp_valid 1 cycle after accept, rsp_err=1, rsp_result=0, alu_opcode unchanged.
- COMP a=3, b=4, rsp_ready held 0 for 5 cycles -> rsp_result=1 stable throughout, cmd_ready=0 until handshake.
- rst_n pulsed low while in CAPTURE -> all outputs at reset values, no rsp_valid, next AND 0xF0 & 0x3C -> 0x30.
- (STATS_EN) 3 legal + 2 illegal commands -> stat_issued=3, stat_err=2.
